// File: rtl/md_unit_if.sv
// Handshake and result bus between the E stage / hazard unit and the
// multiply/divide unit. The CPU side drives the request, the unit drives
// status and the architectural HI/LO values.
interface md_unit_if;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        md_stall;
   logic [31:0] HI;
   logic [31:0] LO;

   // CPU / E-stage side
   modport master (
      output start, md_op, A, B,
      input  busy, md_stall, HI, LO
   );

   // multiply/divide unit side
   modport slave (
      input  start, md_op, A, B,
      output busy, md_stall, HI, LO
   );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed from the operands present at the issue edge and
// parked in pending registers; a down-counter then models the latency and
// the pending value is committed to HI/LO on the edge the counter hits zero.
// MULT_CYCLES and DIV_CYCLES must lie in 1..15 (4-bit counter).
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic      clk,
   input  logic      reset,
   md_unit_if.slave  md
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [0:0]  state;
   logic [3:0]  counter;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [31:0] p_hi;
   logic [31:0] p_lo;
   logic        p_write;   // cleared for divide-by-zero: HI/LO stay untouched

   // ------------------------------------------------------------------
   // Operation decode
   // ------------------------------------------------------------------
   logic is_md_op;
   assign is_md_op = (md.md_op >= OP_MULT) && (md.md_op <= OP_DIVU);

   // ------------------------------------------------------------------
   // Multiply datapath: full 64-bit products from explicitly extended
   // operands so the low 64 bits are exact for both signednesses.
   // ------------------------------------------------------------------
   logic [63:0] a_sx;
   logic [63:0] b_sx;
   logic [63:0] prod_s;
   logic [63:0] prod_u;

   assign a_sx   = {{32{md.A[31]}}, md.A};
   assign b_sx   = {{32{md.B[31]}}, md.B};
   assign prod_s = a_sx * b_sx;
   assign prod_u = {32'd0, md.A} * {32'd0, md.B};

   // ------------------------------------------------------------------
   // Divide datapath. A zero divisor is replaced by 1 so the dividers
   // never see zero; the result is discarded through p_write anyway.
   // Signed division works on magnitudes, which keeps 0x80000000 / -1
   // well defined (magnitude 2^31 negated wraps back to 0x80000000).
   // ------------------------------------------------------------------
   logic        div_zero;
   logic [31:0] divisor;
   logic [31:0] uq;
   logic [31:0] ur;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] sq_mag;
   logic [31:0] sr_mag;
   logic [31:0] sq;
   logic [31:0] sr;

   assign div_zero = (md.B == 32'd0);
   assign divisor  = div_zero ? 32'd1 : md.B;

   assign uq = md.A / divisor;
   assign ur = md.A % divisor;

   assign a_mag  = md.A[31]    ? (~md.A + 32'd1)    : md.A;
   assign b_mag  = divisor[31] ? (~divisor + 32'd1) : divisor;
   assign sq_mag = a_mag / b_mag;
   assign sr_mag = a_mag % b_mag;

   // quotient negative when signs differ; remainder takes dividend's sign
   assign sq = (md.A[31] ^ divisor[31]) ? (~sq_mag + 32'd1) : sq_mag;
   assign sr = md.A[31]                 ? (~sr_mag + 32'd1) : sr_mag;

   // ------------------------------------------------------------------
   // Result selection for the op being issued
   // ------------------------------------------------------------------
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        res_write;
   logic [3:0]  res_load;

   // Pick the pending result, commit enable and latency for this op
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      res_hi    = '0;
      res_lo    = '0;
      res_write = 1'b1;
      res_load  = MULT_LOAD;
      case (md.md_op)
         OP_MULT:  {res_hi, res_lo} = prod_s;
         OP_MULTU: {res_hi, res_lo} = prod_u;
         OP_DIV: begin
            res_hi    = sr;
            res_lo    = sq;
            res_write = ~div_zero;
            res_load  = DIV_LOAD;
         end
         OP_DIVU: begin
            res_hi    = ur;
            res_lo    = uq;
            res_write = ~div_zero;
            res_load  = DIV_LOAD;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Sequencer, pending result and architectural HI/LO
   // ------------------------------------------------------------------

   // Accept ops in IDLE, count down in RUN, commit on the 1->0 edge
   always_ff @(posedge clk) begin
      // NOTE: all state here uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (reset) begin
         state   <= S_IDLE;
         counter <= 4'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         p_hi    <= 32'd0;
         p_lo    <= 32'd0;
         p_write <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (md.start) begin
                  if (is_md_op) begin
                     p_hi    <= res_hi;
                     p_lo    <= res_lo;
                     p_write <= res_write;
                     counter <= res_load;
                     state   <= S_RUN;
                  end else if (md.md_op == OP_MTHI) begin
                     hi_q <= md.A;
                  end else if (md.md_op == OP_MTLO) begin
                     lo_q <= md.A;
                  end
               end
            end
            S_RUN: begin
               // any start during RUN is deliberately ignored
               counter <= counter - 4'd1;
               if (counter == 4'd1) begin
                  state <= S_IDLE;
                  if (p_write) begin
                     hi_q <= p_hi;
                     lo_q <= p_lo;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign md.busy     = (state == S_RUN);
   assign md.md_stall = (md.start && is_md_op) || md.busy;
   assign md.HI       = hi_q;
   assign md.LO       = lo_q;

endmodule
